// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: forwarding-mux select and in-flight destination tracking slot.
package rv32i_types;

    typedef enum logic [1:0] {
        FWD_NONE   = 2'd0,
        FWD_EX_MEM = 2'd1,
        FWD_MEM_WB = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       load_regfile;
        logic       is_load;
    } inflight_t;

    localparam logic [4:0] REG_X0     = 5'd0;
    localparam inflight_t  SLOT_EMPTY = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and async reset, shared by performance monitors.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use hazard detector: tracks EX/MEM destinations and inserts one bubble when
// an ID consumer needs a load result that forwarding cannot yet supply.
module hazard_scoreboard
    import rv32i_types::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [4:0]           id_rs1,
    input  logic [4:0]           id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [4:0]           id_rd,
    input  logic                 id_load_regfile,
    input  logic                 id_is_load,
    input  logic                 freeze,
    input  logic                 flush,
    output logic                 stall_id,
    output logic                 bubble_ex,
    output logic [4:0]           ex_rd,
    output logic [4:0]           mem_rd,
    output logic                 ex_load_regfile,
    output logic                 mem_load_regfile,
    output logic [CNT_WIDTH-1:0] stall_count
);

    inflight_t ex_slot;
    inflight_t mem_slot;
    inflight_t id_entry;
    logic      ex_producer;
    logic      src_match;
    logic      haz;

    // Only a live load writing a non-zero register in EX is too late for forwarding.
    assign ex_producer = ex_slot.valid & ex_slot.is_load & ex_slot.load_regfile &
                         (ex_slot.rd != REG_X0);
    assign src_match   = (id_uses_rs1 & (id_rs1 == ex_slot.rd)) |
                         (id_uses_rs2 & (id_rs2 == ex_slot.rd));
    assign haz         = id_valid & ex_producer & src_match & ~flush;

    always_comb begin
        id_entry              = SLOT_EMPTY;
        id_entry.valid        = 1'b1;
        id_entry.rd           = id_rd;
        id_entry.load_regfile = id_load_regfile;
        id_entry.is_load      = id_is_load;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_slot  <= SLOT_EMPTY;
            mem_slot <= SLOT_EMPTY;
        end else if (!freeze) begin
            mem_slot <= ex_slot;
            if (haz || flush || !id_valid) begin
                ex_slot <= SLOT_EMPTY;
            end else begin
                ex_slot <= id_entry;
            end
        end
    end

    assign stall_id         = haz;
    assign bubble_ex        = haz;
    assign ex_rd            = ex_slot.rd;
    assign mem_rd           = mem_slot.rd;
    assign ex_load_regfile  = ex_slot.valid & ex_slot.load_regfile;
    assign mem_load_regfile = mem_slot.valid & mem_slot.load_regfile;

    sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_stall_counter (
        .clk  (clk),
        .rst  (rst),
        .en   (haz & ~freeze),
        .count(stall_count)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; a second instance with a 2-bit counter checks saturation.
module tb_hazard_scoreboard;

    typedef struct {
        logic       stall;
        logic [4:0] ex_rd;
        logic       ex_lr;
        logic [4:0] mem_rd;
        logic       mem_lr;
        int         cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_uses_rs1, id_uses_rs2, id_load_regfile, id_is_load;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        freeze, flush;
    logic        stall_id, bubble_ex, ex_load_regfile, mem_load_regfile;
    logic [4:0]  ex_rd, mem_rd;
    logic [31:0] stall_count;
    logic        stall_id_n, bubble_ex_n, ex_lr_n, mem_lr_n;
    logic [4:0]  ex_rd_n, mem_rd_n;
    logic [1:0]  stall_count_n;

    exp_t exp_q[$];
    int   total = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_load_regfile(id_load_regfile), .id_is_load(id_is_load),
        .freeze(freeze), .flush(flush), .stall_id(stall_id), .bubble_ex(bubble_ex),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .ex_load_regfile(ex_load_regfile),
        .mem_load_regfile(mem_load_regfile), .stall_count(stall_count)
    );

    hazard_scoreboard #(.CNT_WIDTH(2)) dut_narrow (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_load_regfile(id_load_regfile), .id_is_load(id_is_load),
        .freeze(freeze), .flush(flush), .stall_id(stall_id_n), .bubble_ex(bubble_ex_n),
        .ex_rd(ex_rd_n), .mem_rd(mem_rd_n), .ex_load_regfile(ex_lr_n),
        .mem_load_regfile(mem_lr_n), .stall_count(stall_count_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    task automatic push_exp(input logic es, input logic [4:0] erd, input logic elr,
                            input logic [4:0] mrd, input logic mlr, input int ec);
        exp_t e;
        e.stall = es; e.ex_rd = erd; e.ex_lr = elr; e.mem_rd = mrd; e.mem_lr = mlr; e.cnt = ec;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, ".queue_empty"}, 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, ".stall_id"},   {31'd0, stall_id},         {31'd0, e.stall});
        chk({tag, ".bubble_ex"},  {31'd0, bubble_ex},        {31'd0, e.stall});
        chk({tag, ".ex_rd"},      {27'd0, ex_rd},            {27'd0, e.ex_rd});
        chk({tag, ".ex_lr"},      {31'd0, ex_load_regfile},  {31'd0, e.ex_lr});
        chk({tag, ".mem_rd"},     {27'd0, mem_rd},           {27'd0, e.mem_rd});
        chk({tag, ".mem_lr"},     {31'd0, mem_load_regfile}, {31'd0, e.mem_lr});
        chk({tag, ".count"},      stall_count,               e.cnt);
        chk({tag, ".count_sat"},  {30'd0, stall_count_n},    (e.cnt > 3) ? 32'd3 : e.cnt);
        chk({tag, ".stall_narrow"}, {31'd0, stall_id_n},     {31'd0, e.stall});
    endtask

    // One cycle: drive ID/control at the negedge, check mid-cycle, advance through the posedge.
    task automatic step(input string tag,
                        input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic lr, input logic ld, input logic frz, input logic fl,
                        input logic es, input logic [4:0] erd, input logic elr,
                        input logic [4:0] mrd, input logic mlr, input int ec);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        id_rd = rd; id_load_regfile = lr; id_is_load = ld; freeze = frz; flush = fl;
        push_exp(es, erd, elr, mrd, mlr, ec);
        #1;
        pop_check(tag);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        id_rd = 0; id_load_regfile = 0; id_is_load = 0; freeze = 0; flush = 0;
        @(negedge clk);
        push_exp(0, 0, 0, 0, 0, 0);
        #1;
        pop_check("reset");
        rst = 1'b0;
        @(negedge clk);

        //    tag        v  rs1 rs2 u1 u2 rd  lr ld frz fl | stall exrd exlr memrd memlr cnt
        step("lw_x5",    1, 0,  0,  0, 0, 5,  1, 1, 0, 0,    0, 0,  0, 0,  0, 0);
        step("use_x5",   1, 5,  1,  1, 1, 6,  1, 0, 0, 0,    1, 5,  1, 0,  0, 0);
        step("use_go",   1, 5,  1,  1, 1, 6,  1, 0, 0, 0,    0, 0,  0, 5,  1, 1);
        step("lw_x0",    1, 0,  0,  0, 0, 0,  1, 1, 0, 0,    0, 6,  1, 0,  0, 1);
        step("use_x0",   1, 0,  0,  1, 0, 7,  1, 0, 0, 0,    0, 0,  1, 6,  1, 1);
        step("addi_x5",  1, 1,  0,  1, 0, 5,  1, 0, 0, 0,    0, 7,  1, 0,  1, 1);
        step("use_alu",  1, 5,  0,  1, 0, 8,  1, 0, 0, 0,    0, 5,  1, 7,  1, 1);
        step("lw_x9",    1, 0,  0,  0, 0, 9,  1, 1, 0, 0,    0, 8,  1, 5,  1, 1);
        step("frz1",     1, 0,  9,  0, 1, 10, 1, 0, 1, 0,    1, 9,  1, 8,  1, 1);
        step("frz2",     1, 0,  9,  0, 1, 10, 1, 0, 1, 0,    1, 9,  1, 8,  1, 1);
        step("frz3",     1, 0,  9,  0, 1, 10, 1, 0, 1, 0,    1, 9,  1, 8,  1, 1);
        step("unfrz",    1, 0,  9,  0, 1, 10, 1, 0, 0, 0,    1, 9,  1, 8,  1, 1);
        step("frz_go",   1, 0,  9,  0, 1, 10, 1, 0, 0, 0,    0, 0,  0, 9,  1, 2);
        step("lw_x11",   1, 0,  0,  0, 0, 11, 1, 1, 0, 0,    0, 10, 1, 0,  0, 2);
        step("flush",    1, 11, 0,  1, 0, 12, 1, 0, 0, 1,    0, 11, 1, 10, 1, 2);
        step("post_fl",  0, 0,  0,  0, 0, 0,  0, 0, 0, 0,    0, 0,  0, 11, 1, 2);
        step("lw_x7a",   1, 0,  0,  0, 0, 7,  1, 1, 0, 0,    0, 0,  0, 0,  0, 2);
        step("rs2_only", 1, 7,  7,  0, 1, 13, 1, 0, 0, 0,    1, 7,  1, 0,  0, 2);
        step("idle1",    0, 0,  0,  0, 0, 0,  0, 0, 0, 0,    0, 0,  0, 7,  1, 3);
        step("lw_x7b",   1, 0,  0,  0, 0, 7,  1, 1, 0, 0,    0, 0,  0, 0,  0, 3);
        step("no_uses",  1, 7,  7,  0, 0, 13, 1, 0, 0, 0,    0, 7,  1, 0,  0, 3);
        step("idle2",    0, 0,  0,  0, 0, 0,  0, 0, 0, 0,    0, 13, 1, 7,  1, 3);
        step("lw_x1",    1, 0,  0,  0, 0, 1,  1, 1, 0, 0,    0, 0,  0, 13, 1, 3);
        step("lw_x2_h",  1, 1,  0,  1, 0, 2,  1, 1, 0, 0,    1, 1,  1, 0,  0, 3);
        step("lw_x2_go", 1, 1,  0,  1, 0, 2,  1, 1, 0, 0,    0, 0,  0, 1,  1, 4);
        step("add_x2_h", 1, 2,  0,  1, 0, 3,  1, 0, 0, 0,    1, 2,  1, 0,  0, 4);
        step("add_go",   1, 2,  0,  1, 0, 3,  1, 0, 0, 0,    0, 0,  0, 2,  1, 5);
        step("lw_x4",    1, 0,  0,  0, 0, 4,  1, 1, 0, 0,    0, 3,  1, 0,  0, 5);

        // Load-use on x4 is active; an async reset mid-cycle must clear everything at once.
        id_valid = 1; id_rs1 = 4; id_rs2 = 0; id_uses_rs1 = 1; id_uses_rs2 = 0;
        id_rd = 5; id_load_regfile = 1; id_is_load = 0; freeze = 0; flush = 0;
        push_exp(1, 4, 1, 3, 1, 5);
        #1;
        pop_check("pre_rst");
        rst = 1'b1;
        push_exp(0, 0, 0, 0, 0, 0);
        #1;
        pop_check("mid_rst");
        rst = 1'b0;
        id_valid = 0;
        @(negedge clk);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Producer-side companion to the EX-stage forwarding mux selection. It tracks the destination registers of in-flight instructions in EX and MEM and decides when an ID-stage consumer cannot be served by forwarding (load-use). In that case it holds IF/ID and injects a bubble into ID/EX for exactly one advancing cycle. It sits beside the ID/EX pipeline register, sees the same freeze and flush controls as the pipeline registers, and exposes a saturating stall counter for performance monitoring.

## Interface
- `CNT_WIDTH`, default 32: width of the load-use stall counter.

- `clk`  in  1  pipeline clock.
- `rst`  in  1  asynchronous, active-high reset.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs1`, `id_rs2`  in  5  ID source register indices.
- `id_uses_rs1`, `id_uses_rs2`  in  1  the ID instruction reads that source.
- `id_rd`  in  5  ID destination register index.
- `id_load_regfile`  in  1  the ID instruction writes `rd`.
- `id_is_load`  in  1  the ID instruction is a load.
- `freeze`  in  1  global pipeline hold (cache miss); no stage advances.
- `flush`  in  1  branch mispredict; the instruction leaving ID is squashed.
- `stall_id`  out  1  hold PC and IF/ID this cycle.
- `bubble_ex`  out  1  load a NOP into ID/EX this cycle.
- `ex_rd`, `mem_rd`  out  5  tracked destinations, exported for debug and assertions.
- `ex_load_regfile`, `mem_load_regfile`  out  1  tracked write-enables, with valid folded in.
- `stall_count`  out  CNT_WIDTH  number of load-use bubbles inserted, saturating.

## Operation
- Two tracking slots, `ex_slot` and `mem_slot`, each holding {valid, rd, load_regfile, is_load}.
- Hazard condition: `haz = id_valid & ex_slot.valid & ex_slot.is_load & ex_slot.load_regfile & ex_slot.rd != 0 & ((id_uses_rs1 & id_rs1 == ex_slot.rd) | (id_uses_rs2 & id_rs2 == ex_slot.rd)) & !flush`.
- Outputs: `stall_id = haz` and `bubble_ex = haz`. Both are combinational from registered slot state and ID inputs.
- Slot update on a rising `clk` edge when `freeze` = 0:
  - `mem_slot <= ex_slot`.
  - `ex_slot <=` invalid if `haz | flush | !id_valid`; otherwise the ID fields with valid = 1.
- Slot update when `freeze` = 1: both slots hold. `stall_id` and `bubble_ex` still reflect `haz`, but the pipeline registers ignore them while frozen.
- `flush` and `haz` together: `flush` wins, so `haz` is forced to 0 and `ex_slot` becomes invalid.
- Writes to x0 never create a hazard. A load to x0 is tracked but inert.
- Non-load producers in EX never stall; EX/MEM forwarding covers them. A load in MEM never stalls; MEM/WB forwarding covers it.
- `ex_load_regfile` = `ex_slot.valid & ex_slot.load_regfile`. `mem_load_regfile` is formed the same way from `mem_slot`.
- `stall_count` increments by 1 on each edge where `haz & !freeze`. It saturates at all-ones and never wraps.

## Timing
- Reset (async assert): both slots invalid with rd = 0, `stall_count` = 0. With `id_valid` low, every output is 0.
- Reset deasserts synchronously to `clk` externally. The first edge after release updates normally.
- A load-use pair costs exactly one advancing cycle of bubble:
  - Cycle N: load in EX, consumer in ID, `haz` = 1.
  - Edge N+1: the load moves to MEM and `ex_slot` becomes a bubble.
  - Cycle N+1: `haz` = 0 and the consumer advances; forwarding then selects the MEM/WB path.
- A freeze during cycle N stretches the stall: `haz` stays 1 until the first unfrozen edge.
- Back-to-back loads feeding each other give one bubble per dependent pair.
- A reset asserted mid-stall clears the slots immediately, and `stall_id` drops in the same cycle.

## Structure
- The slot typedef `inflight_t` {logic valid; logic [4:0] rd; logic load_regfile; logic is_load;} belongs in `rv32i_types`, next to the forwarding-mux select enum.
- Natural sub-module: `sat_counter` (parameterised width, enable, async reset) for `stall_count`, reusable by other performance counters.

## Test plan
- Load `lw x5` in EX, `add x6,x5,x1` in ID -> `stall_id` = `bubble_ex` = 1 for one cycle; next cycle 0; `stall_count` = 1.
- `lw x0` in EX, consumer reads x0 -> no stall; ALU-op `addi x5` in EX, consumer reads x5 -> no stall.
- Load-use with `freeze` high for 3 cycles -> `stall_id` held for 4 cycles total; `stall_count` = 1; slots unchanged while frozen.
- Load-use coincident with `flush` -> `stall_id` = 0; next cycle `ex_load_regfile` = 0; `stall_count` unchanged.
- Consumer uses only rs2 = x7 with rs1 = x7 but `id_uses_rs1` = 0, load to x7 in EX -> stall; repeat with `id_uses_rs2` = 0 -> no stall.
- `CNT_WIDTH` = 2, five load-use events -> `stall_count` = 3 and holds; async `rst` pulse mid-stall -> all outputs 0 immediately.
